// File: rtl/i2c_master_arbiter_if.sv
// ============================================================================
//  Module : i2c_master_arbiter_if
//  Brief  : Requester-side and master-side signal bundle for the I2C arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface i2c_master_arbiter_if;
  logic [1:0]  req;
  logic [13:0] req_addr;
  logic [1:0]  req_rnw;
  logic [3:0]  req_size;
  logic [15:0] req_wdata;
  logic [1:0]  req_wvalid;
  logic [1:0]  grant;
  logic [1:0]  wreq;
  logic [7:0]  rdata;
  logic [1:0]  rvalid;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_rnw;
  logic [1:0]  m_size;
  logic [7:0]  m_data_i;
  logic        m_data_valid;
  logic        m_busy;
  logic        m_newData;
  logic        m_dataReq;
  logic [7:0]  m_data_o;

  // Arbiter view
  modport slave (
    input  req, req_addr, req_rnw, req_size, req_wdata, req_wvalid,
    input  m_busy, m_newData, m_dataReq, m_data_o,
    output grant, wreq, rdata, rvalid, done, err,
    output m_start, m_addr, m_rnw, m_size, m_data_i, m_data_valid
  );

  // System / requester / master-core view
  modport master (
    output req, req_addr, req_rnw, req_size, req_wdata, req_wvalid,
    output m_busy, m_newData, m_dataReq, m_data_o,
    input  grant, wreq, rdata, rvalid, done, err,
    input  m_start, m_addr, m_rnw, m_size, m_data_i, m_data_valid
  );
endinterface

`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
// ============================================================================
//  Module : i2c_master_arbiter
//  Brief  : Round-robin sharing of one I2C master core between two requesters.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module i2c_master_arbiter #(
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  i2c_master_arbiter_if.slave bus
);

  localparam int              c_CW       = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_XFER      = 3'd3,
    S_DONE      = 3'd4,
    S_ABORT     = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_grant, w_grant_nxt;
  logic            r_last, w_last_nxt;
  logic            r_start, w_start_nxt;
  logic [6:0]      r_addr, w_addr_nxt;
  logic            r_rnw, w_rnw_nxt;
  logic [1:0]      r_size, w_size_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]      r_wreq, w_wreq_nxt;
  logic [1:0]      r_rvalid, w_rvalid_nxt;
  logic [1:0]      r_done, w_done_nxt;
  logic [1:0]      r_err, w_err_nxt;
  logic [7:0]      r_rdata, w_rdata_nxt;
  logic            r_dreq_d;
  logic            r_nd_d;
  logic            w_win;

  // On a tie the requester that was not served last wins
  assign w_win = (bus.req == 2'b11) ? ~r_last : bus.req[1];

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_start_nxt  = 1'b0;
    w_addr_nxt   = r_addr;
    w_rnw_nxt    = r_rnw;
    w_size_nxt   = r_size;
    w_cnt_nxt    = r_cnt;
    w_wreq_nxt   = 2'b00;
    w_rvalid_nxt = 2'b00;
    w_done_nxt   = 2'b00;
    w_err_nxt    = 2'b00;
    w_rdata_nxt  = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_grant_nxt = w_win ? 2'b10 : 2'b01;
          w_addr_nxt  = w_win ? bus.req_addr[13:7] : bus.req_addr[6:0];
          w_rnw_nxt   = w_win ? bus.req_rnw[1]     : bus.req_rnw[0];
          w_size_nxt  = w_win ? bus.req_size[3:2]  : bus.req_size[1:0];
          w_start_nxt = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.m_busy) begin
          w_state_nxt = S_XFER;
        end else if (r_cnt == c_CNT_LAST) begin
          w_err_nxt   = r_grant;
          w_state_nxt = S_ABORT;
        end else begin
          w_cnt_nxt = r_cnt + c_CW'(1);
        end
      end
      S_XFER: begin
        if (bus.m_dataReq && !r_dreq_d) begin
          w_wreq_nxt = r_grant;
        end
        if (bus.m_newData && !r_nd_d) begin
          w_rdata_nxt  = bus.m_data_o;
          w_rvalid_nxt = r_grant;
        end
        if (!bus.m_busy) begin
          w_done_nxt  = r_grant;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE, S_ABORT: begin
        w_last_nxt  = r_grant[1];
        w_grant_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_start  <= 1'b0;
      r_addr   <= 7'd0;
      r_rnw    <= 1'b0;
      r_size   <= 2'b00;
      r_cnt    <= '0;
      r_wreq   <= 2'b00;
      r_rvalid <= 2'b00;
      r_done   <= 2'b00;
      r_err    <= 2'b00;
      r_rdata  <= 8'h00;
      r_dreq_d <= 1'b0;
      r_nd_d   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_start  <= w_start_nxt;
      r_addr   <= w_addr_nxt;
      r_rnw    <= w_rnw_nxt;
      r_size   <= w_size_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wreq   <= w_wreq_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_rdata  <= w_rdata_nxt;
      r_dreq_d <= bus.m_dataReq;
      r_nd_d   <= bus.m_newData;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.wreq    = r_wreq;
  assign bus.rdata   = r_rdata;
  assign bus.rvalid  = r_rvalid;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.m_start = r_start;
  assign bus.m_addr  = r_addr;
  assign bus.m_rnw   = r_rnw;
  assign bus.m_size  = r_size;

  // Write path is a plain mux so the byte reaches the master in the cycle it is asked for
  assign bus.m_data_i     = r_grant[0] ? bus.req_wdata[7:0]  :
                            r_grant[1] ? bus.req_wdata[15:8] : 8'h00;
  assign bus.m_data_valid = r_grant[0] ? bus.req_wvalid[0] :
                            r_grant[1] ? bus.req_wvalid[1] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
// ============================================================================
//  Module : tb_i2c_master_arbiter
//  Brief  : Scoreboard bench for i2c_master_arbiter with a behavioural master core.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_master_arbiter;

  localparam logic [2:0] K_START = 3'd0, K_WREQ = 3'd1, K_RVALID = 3'd2, K_DONE = 3'd3, K_ERR = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [1:0] gnt;
    logic [7:0] d;
    logic [9:0] a;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  i2c_master_arbiter_if bus();

  i2c_master_arbiter #(.BUSY_TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ev_t        sb[$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         start_cyc = 0;
  int         hold_left = 0;
  bit         never_busy = 1'b0;
  logic [7:0] rbytes [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_START:  return "start";
      K_WREQ:   return "wreq";
      K_RVALID: return "rvalid";
      K_DONE:   return "done";
      default:  return "err";
    endcase
  endfunction

  task automatic push(input logic [2:0] k, input logic [1:0] g, input logic [7:0] d, input logic [9:0] a);
    ev_t e;
    e.kind = k; e.gnt = g; e.d = d; e.a = a;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input logic [2:0] k, input logic [1:0] g, input logic [7:0] d, input logic [9:0] a);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got gnt=%b d=%h a=%h, expected no event", kname(k), g, d, a);
    end else begin
      e = sb.pop_front();
      if (e.kind !== k || e.gnt !== g || e.d !== d || e.a !== a) begin
        n_fail++;
        $display("FAIL sb_%s: got %s gnt=%b d=%h a=%h, expected %s gnt=%b d=%h a=%h",
                 kname(e.kind), kname(k), g, d, a, kname(e.kind), e.gnt, e.d, e.a);
      end
    end
  endtask

  // Monitor: every output event is matched against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      if (bus.m_start) begin
        start_cyc <= cyc;
        sb_pop(K_START, bus.grant, 8'h00, {bus.m_addr, bus.m_rnw, bus.m_size});
      end
      if (|bus.wreq)   sb_pop(K_WREQ, bus.wreq, bus.m_data_i, {9'd0, bus.m_data_valid});
      if (|bus.rvalid) sb_pop(K_RVALID, bus.rvalid, bus.rdata, 10'd0);
      if (|bus.done)   sb_pop(K_DONE, bus.done, 8'h00, 10'd0);
      if (|bus.err) begin
        sb_pop(K_ERR, bus.err, 8'h00, 10'd0);
        check("err_latency", cyc - start_cyc, 256);
      end
    end
  end

  // Behavioural master core: busy for 20 cycles, two data events
  initial begin
    bit rd;
    bus.m_busy = 1'b0; bus.m_dataReq = 1'b0; bus.m_newData = 1'b0; bus.m_data_o = 8'h00;
    forever begin
      @(negedge clk);
      if (rst && bus.m_start && !never_busy) begin
        rd = bus.m_rnw;
        repeat (2) @(posedge clk);
        #1 bus.m_busy = 1'b1;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (!rst) break;
          if (c == 4 || c == 10) begin
            if (rd) begin
              bus.m_data_o  = rbytes[(c == 10) ? 1 : 0];
              bus.m_newData = 1'b1;
            end else begin
              bus.m_dataReq = 1'b1;
            end
          end
          if (c == 6 || c == 12) begin
            bus.m_newData = 1'b0;
            bus.m_dataReq = 1'b0;
          end
        end
        bus.m_busy = 1'b0; bus.m_newData = 1'b0; bus.m_dataReq = 1'b0;
      end
    end
  end

  task automatic exp_write(input logic [1:0] g, input logic [6:0] a, input logic [1:0] sz, input logic [7:0] wd);
    push(K_START, g, 8'h00, {a, 1'b0, sz});
    push(K_WREQ, g, wd, 10'd1);
    push(K_WREQ, g, wd, 10'd1);
    push(K_DONE, g, 8'h00, 10'd0);
  endtask

  task automatic exp_read(input logic [1:0] g, input logic [6:0] a, input logic [1:0] sz,
                          input logic [7:0] b0, input logic [7:0] b1);
    push(K_START, g, 8'h00, {a, 1'b1, sz});
    push(K_RVALID, g, b0, 10'd0);
    push(K_RVALID, g, b1, 10'd0);
    push(K_DONE, g, 8'h00, 10'd0);
  endtask

  // Requesters drop req on done/err unless a held run is in progress
  task automatic run_until_idle(input int max_cyc, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (|(bus.done | bus.err)) begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) bus.req = 2'b00;
        end else begin
          bus.req = bus.req & ~(bus.done | bus.err);
        end
      end
      if (sb.size() == 0 && bus.grant == 2'b00 && bus.req == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: got pending=%0d grant=%b req=%b, expected all idle", name, sb.size(), bus.grant, bus.req);
    end
  endtask

  initial begin
    bus.req        = 2'b00;
    bus.req_addr   = {7'h51, 7'h40};
    bus.req_rnw    = 2'b00;
    bus.req_size   = {2'b10, 2'b01};
    bus.req_wdata  = {8'h22, 8'h11};
    bus.req_wvalid = 2'b11;
    rbytes[0] = 8'hA5;
    rbytes[1] = 8'h3C;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", bus.grant, 2'b00);
    check("rst_pulses", {bus.m_start, bus.wreq, bus.rvalid, bus.done, bus.err}, 9'd0);
    check("rst_m_addr", {bus.m_addr, bus.m_rnw, bus.m_size}, 10'd0);
    check("rst_m_data", {bus.m_data_i, bus.m_data_valid}, 9'd0);
    check("rst_rdata", bus.rdata, 8'h00);
    @(negedge clk) rst = 1'b1;

    // Single write from requester 0
    @(posedge clk); #1;
    exp_write(2'b01, 7'h40, 2'b01, 8'h11);
    bus.req = 2'b01;
    run_until_idle(100, "t1");

    // Tie straight after reset: requester 0 first, then 1
    rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    exp_write(2'b01, 7'h40, 2'b01, 8'h11);
    exp_write(2'b10, 7'h51, 2'b10, 8'h22);
    bus.req = 2'b11;
    run_until_idle(200, "t2");

    // Read by requester 1
    bus.req_rnw = 2'b10;
    @(posedge clk); #1;
    exp_read(2'b10, 7'h51, 2'b10, 8'hA5, 8'h3C);
    bus.req = 2'b10;
    run_until_idle(100, "t3");
    check("rdata_hold", bus.rdata, 8'h3C);
    bus.req_rnw = 2'b00;

    // Busy never rises: abort, then a fresh request is still served
    never_busy = 1'b1;
    @(posedge clk); #1;
    push(K_START, 2'b01, 8'h00, {7'h40, 1'b0, 2'b01});
    push(K_ERR, 2'b01, 8'h00, 10'd0);
    bus.req = 2'b01;
    run_until_idle(400, "t4");
    never_busy = 1'b0;
    @(posedge clk); #1;
    exp_write(2'b01, 7'h40, 2'b01, 8'h11);
    bus.req = 2'b01;
    run_until_idle(100, "t4b");

    // Reset in the middle of a transfer
    @(posedge clk); #1;
    push(K_START, 2'b01, 8'h00, {7'h40, 1'b0, 2'b01});
    bus.req = 2'b01;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.m_busy) begin seen = 1'b1; break; end
      end
      check("t5_busy_seen", seen, 1'b1);
    end
    @(posedge clk); @(posedge clk); #2;
    check("t5_grant_before", bus.grant, 2'b01);
    rst = 1'b0;
    #1;
    check("t5_grant", bus.grant, 2'b00);
    check("t5_pulses", {bus.m_start, bus.wreq, bus.rvalid, bus.done, bus.err}, 9'd0);
    check("t5_m_addr", bus.m_addr, 7'd0);
    sb.delete();
    bus.req = 2'b00;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_write(2'b10, 7'h51, 2'b10, 8'h22);
    bus.req = 2'b10;
    run_until_idle(100, "t5");

    // Held tie over four transactions alternates owners
    @(posedge clk); #1;
    exp_write(2'b01, 7'h40, 2'b01, 8'h11);
    exp_write(2'b10, 7'h51, 2'b10, 8'h22);
    exp_write(2'b01, 7'h40, 2'b01, 8'h11);
    exp_write(2'b10, 7'h51, 2'b10, 8'h22);
    hold_left = 4;
    bus.req = 2'b11;
    run_until_idle(400, "t6");

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
